// File: rtl/ts_sync_filter_pkg.sv
// Shared constants and FSM encoding for the TS sync filter.
// Used by the top and by the saturating counter.
package ts_sync_filter_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         TS_PKT_LEN   = 188;
   localparam int         TS_CNT_W     = 16;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } ts_state_e;

endpackage

// File: rtl/ts_sync_filter_sat_counter.sv
// 16-bit event counter that sticks at all-ones.
// Its synchronous clear wins over a same-cycle increment.
module ts_sat_counter
   import ts_sync_filter_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                inc_i,
   output logic [TS_CNT_W-1:0] cnt_o
);

   logic [TS_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ts_sync_filter.sv
// Acquires 188-byte TS alignment on 0x47 and forwards only whole, synced packets
// one cycle after input, marking byte 0 with TS_PSYNC_OUT.
module ts_sync_filter
   import ts_sync_filter_pkg::*;
#(
   parameter int PKT_LEN    = TS_PKT_LEN,
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  TS_DATA_IN,
   input  logic        TS_DVALID_IN,
   input  logic        CNT_CLR,
   output logic [7:0]  TS_DATA_OUT,
   output logic        TS_DVALID_OUT,
   output logic        TS_PSYNC_OUT,
   output logic        LOCKED,
   output logic [15:0] DROP_CNT,
   output logic [15:0] LOSS_CNT
);

   localparam int PW = $clog2(PKT_LEN);
   localparam int HW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(LOSS_COUNT + 1);
   localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);
   localparam logic [HW-1:0] LOCK_C   = HW'(LOCK_COUNT);
   localparam logic [MW-1:0] LOSS_C   = MW'(LOSS_COUNT);

   ts_state_e     state_q;
   logic [PW-1:0] pos_q, pos_d;
   logic [HW-1:0] hits_q, hits_d;
   logic [MW-1:0] miss_q, miss_d;
   logic          fwd_q;
   logic [7:0]    data_q;
   logic          dvalid_q, psync_q, locked_q;
   logic          sync_chk, is_sync, drop_inc, loss_inc;

   always_comb begin
      pos_d    = (pos_q == PKT_LAST) ? '0 : pos_q + 1'b1;
      hits_d   = hits_q + 1'b1;
      miss_d   = miss_q + 1'b1;
      is_sync  = (TS_DATA_IN == TS_SYNC_BYTE);
      sync_chk = TS_DVALID_IN && (pos_q == '0);
      drop_inc = (state_q == ST_LOCKED) && sync_chk && !is_sync;
      loss_inc = drop_inc && (miss_d == LOSS_C);
   end

   // Output registers only load data on a forwarded byte, so data holds across gaps.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_HUNT;
         pos_q    <= '0;
         hits_q   <= '0;
         miss_q   <= '0;
         fwd_q    <= 1'b0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         psync_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         dvalid_q <= 1'b0;
         psync_q  <= 1'b0;
         if (TS_DVALID_IN) begin
            case (state_q)
               ST_HUNT: begin
                  if (is_sync) begin
                     state_q <= ST_VERIFY;
                     hits_q  <= HW'(1);
                     pos_q   <= PW'(1);
                  end
               end
               ST_VERIFY: begin
                  pos_q <= pos_d;
                  if (sync_chk) begin
                     if (!is_sync) begin
                        state_q <= ST_HUNT;
                     end else if (hits_d == LOCK_C) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                        fwd_q    <= 1'b1;
                        data_q   <= TS_DATA_IN;
                        dvalid_q <= 1'b1;
                        psync_q  <= 1'b1;
                     end else begin
                        hits_q <= hits_d;
                     end
                  end
               end
               ST_LOCKED: begin
                  pos_q <= pos_d;
                  if (sync_chk) begin
                     if (is_sync) begin
                        miss_q   <= '0;
                        fwd_q    <= 1'b1;
                        data_q   <= TS_DATA_IN;
                        dvalid_q <= 1'b1;
                        psync_q  <= 1'b1;
                     end else begin
                        miss_q <= miss_d;
                        fwd_q  <= 1'b0;
                        if (loss_inc) begin
                           state_q  <= ST_HUNT;
                           locked_q <= 1'b0;
                        end
                     end
                  end else if (fwd_q) begin
                     data_q   <= TS_DATA_IN;
                     dvalid_q <= 1'b1;
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end

   ts_sat_counter u_drop_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (CNT_CLR),
      .inc_i (drop_inc),
      .cnt_o (DROP_CNT)
   );

   ts_sat_counter u_loss_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (CNT_CLR),
      .inc_i (loss_inc),
      .cnt_o (LOSS_CNT)
   );

   assign TS_DATA_OUT   = data_q;
   assign TS_DVALID_OUT = dvalid_q;
   assign TS_PSYNC_OUT  = psync_q;
   assign LOCKED        = locked_q;

endmodule

// File: tb/tb_ts_sync_filter.sv
// Directed bench for ts_sync_filter: lock acquisition, drops, lock loss,
// false sync, input gaps, async reset and counter clear.
module tb_ts_sync_filter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        dv  = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  dout;
   logic        dvo, pso, locked;
   logic [15:0] drop_cnt, loss_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  last_data = 8'h00;
   logic [15:0] drop_at0 = 16'h0;
   logic        locked_at0 = 1'b0;

   ts_sync_filter dut (
      .CLK           (CLK),
      .RST           (RST),
      .TS_DATA_IN    (din),
      .TS_DVALID_IN  (dv),
      .CNT_CLR       (clr),
      .TS_DATA_OUT   (dout),
      .TS_DVALID_OUT (dvo),
      .TS_PSYNC_OUT  (pso),
      .LOCKED        (locked),
      .DROP_CNT      (drop_cnt),
      .LOSS_CNT      (loss_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Payload bytes stay in 0x80..0xBF so they never look like a sync byte.
   function automatic logic [7:0] pl(input int p, input int k);
      return 8'h80 | 8'((p * 5 + k) % 64);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic [7:0] d, input logic c);
      @(negedge CLK);
      dv  = v;
      din = d;
      clr = c;
      @(posedge CLK);
      #1;
      dv  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic send_pkt(input int p, input logic [7:0] sync, input int fake, input bit fwd,
                           input int gapmax, input int n, input bit clr0, input string tag);
      int         bad;
      int         g;
      logic [7:0] b;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         repeat (g) begin
            cyc(1'b0, 8'h00, 1'b0);
            if (dvo !== 1'b0 || pso !== 1'b0 || dout !== last_data) bad++;
         end
         b = (k == 0) ? sync : ((k == fake) ? 8'h47 : pl(p, k));
         cyc(1'b1, b, clr0 && (k == 0));
         if (fwd) last_data = b;
         if (dvo !== fwd || pso !== (fwd && k == 0) || dout !== last_data) bad++;
         if (k == 0) begin
            drop_at0   = drop_cnt;
            locked_at0 = locked;
         end
      end
      chk(tag, bad, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      last_data = 8'h00;
   endtask

   initial begin
      #2 RST = 1'b1;
      #1;
      chk("rst_dvalid", dvo, 0);
      chk("rst_psync", pso, 0);
      chk("rst_data", dout, 0);
      chk("rst_locked", locked, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_loss", loss_cnt, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      // clean stream: lock on the third sync byte
      send_pkt(1, 8'h47, -1, 0, 0, 188, 0, "clean_p1_silent");
      chk("p1_unlocked", locked, 0);
      send_pkt(2, 8'h47, -1, 0, 0, 188, 0, "clean_p2_silent");
      chk("p2_unlocked", locked, 0);
      send_pkt(3, 8'h47, -1, 1, 0, 188, 0, "clean_p3_fwd");
      chk("p3_locked_at_psync", locked_at0, 1);
      send_pkt(4, 8'h47, -1, 1, 0, 188, 0, "clean_p4_fwd");
      send_pkt(5, 8'h47, -1, 1, 0, 188, 0, "clean_p5_fwd");
      chk("clean_drop", drop_cnt, 0);
      chk("clean_loss", loss_cnt, 0);

      // single bad sync while locked
      send_pkt(6, 8'h46, -1, 0, 0, 188, 0, "bad_p6_suppressed");
      chk("drop_latency", drop_at0, 1);
      chk("drop_one", drop_cnt, 1);
      chk("still_locked", locked, 1);
      send_pkt(7, 8'h47, -1, 1, 0, 188, 0, "p7_fwd");

      cyc(1'b0, 8'h00, 1'b1);
      chk("cnt_clr_idle", drop_cnt, 0);

      // three bad syncs: lock lost, then relock
      send_pkt(8, 8'h00, -1, 0, 0, 188, 0, "bad_p8");
      send_pkt(9, 8'h12, -1, 0, 0, 188, 0, "bad_p9");
      chk("locked_before_third", locked_at0, 1);
      chk("drop_two", drop_cnt, 2);
      send_pkt(10, 8'h46, -1, 0, 0, 188, 0, "bad_p10");
      chk("lock_fall_latency", locked_at0, 0);
      chk("drop_three", drop_cnt, 3);
      chk("loss_one", loss_cnt, 1);
      send_pkt(11, 8'h47, -1, 0, 0, 188, 0, "relock_p11_silent");
      send_pkt(12, 8'h47, -1, 0, 0, 188, 0, "relock_p12_silent");
      chk("relock_pending", locked, 0);
      send_pkt(13, 8'h47, -1, 1, 0, 188, 0, "relock_p13_fwd");
      chk("relocked", locked, 1);

      // false 0x47 at payload offset 10 during hunt
      do_reset();
      send_pkt(14, 8'h00, 10, 0, 0, 188, 0, "false_p14_silent");
      send_pkt(15, 8'h47, -1, 0, 0, 188, 0, "false_p15_silent");
      chk("false_unlocked", locked, 0);
      send_pkt(16, 8'h47, -1, 0, 0, 188, 0, "false_p16_silent");
      send_pkt(17, 8'h47, -1, 0, 0, 188, 0, "false_p17_silent");
      send_pkt(18, 8'h47, -1, 1, 0, 188, 0, "false_p18_fwd");
      chk("false_locked_at_psync", locked_at0, 1);
      chk("false_no_drop", drop_cnt, 0);

      // random input gaps
      do_reset();
      send_pkt(19, 8'h47, -1, 0, 5, 188, 0, "gap_p19_silent");
      send_pkt(20, 8'h47, -1, 0, 5, 188, 0, "gap_p20_silent");
      send_pkt(21, 8'h47, -1, 1, 5, 188, 0, "gap_p21_fwd");
      chk("gap_locked", locked, 1);

      // async reset at packet byte 50 while locked
      send_pkt(22, 8'h47, -1, 1, 0, 50, 0, "rstmid_p22_head");
      @(negedge CLK);
      dv  = 1'b1;
      din = pl(22, 50);
      #1 RST = 1'b1;
      #1;
      chk("arst_dvalid", dvo, 0);
      chk("arst_psync", pso, 0);
      chk("arst_data", dout, 0);
      chk("arst_locked", locked, 0);
      dv = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      last_data = 8'h00;
      send_pkt(24, 8'h47, -1, 0, 0, 188, 0, "arst_p24_silent");
      send_pkt(25, 8'h47, -1, 0, 0, 188, 0, "arst_p25_silent");
      send_pkt(26, 8'h47, -1, 1, 0, 188, 0, "arst_p26_fwd");
      chk("arst_relocked", locked, 1);

      // CNT_CLR coincident with a drop
      send_pkt(27, 8'h46, -1, 0, 0, 188, 1, "clr_p27_suppressed");
      chk("clr_wins_drop", drop_cnt, 0);
      chk("clr_keeps_lock", locked, 1);
      send_pkt(28, 8'h46, -1, 0, 0, 188, 0, "p28_suppressed");
      chk("drop_after_clr", drop_cnt, 1);
      send_pkt(29, 8'h47, -1, 1, 0, 188, 0, "p29_fwd");
      chk("final_locked", locked, 1);
      chk("final_loss", loss_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_sync_filter.md
# ts_sync_filter

Transport-stream input conditioner that sits directly upstream of the T2-MI packer, between the raw parallel TS receiver (DATA/DCLK/RDY/SC_D) and the packer's TS input. It acquires and tracks 188-byte packet alignment on the 0x47 sync byte and forwards only whole, correctly synced packets. It marks each packet start and reports lock state and error statistics. The packer can therefore assume every valid byte it receives belongs to an aligned packet.

## Interface
- PKT_LEN, 188: packet length in bytes.
- LOCK_COUNT, 3: consecutive good sync bytes (≥2) required to declare lock.
- LOSS_COUNT, 3: consecutive bad sync bytes (≥1) while locked that drop lock.
- CLK  in  1  byte clock (TS DCLK domain); one clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- TS_DATA_IN  in  8  input byte.
- TS_DVALID_IN  in  1  input byte valid; gaps of any length are allowed.
- CNT_CLR  in  1  synchronous clear of DROP_CNT and LOSS_CNT.
- TS_DATA_OUT  out  8  forwarded byte.
- TS_DVALID_OUT  out  1  forwarded byte valid.
- TS_PSYNC_OUT  out  1  high with byte 0 (0x47) of each forwarded packet.
- LOCKED  out  1  high while in state LOCKED.
- DROP_CNT  out  16  packets discarded while locked; saturates at 0xFFFF.
- LOSS_CNT  out  16  lock-loss events; saturates at 0xFFFF.

## Operation
- Position counter POS, range 0..PKT_LEN-1:
  - Advances only on TS_DVALID_IN=1 and wraps PKT_LEN-1 → 0.
  - Meaningful only in VERIFY and LOCKED.
  - A "sync check" occurs on a valid byte with POS=0.
- FSM states: HUNT, VERIFY, LOCKED. Reset state is HUNT.
- HUNT:
  - Valid byte == 0x47 → VERIFY, with hits=1 and POS←1.
  - Any other valid byte: stay in HUNT.
  - No output.
- VERIFY:
  - Sync check with 0x47: hits+1.
    - If the incremented hits == LOCK_COUNT → LOCKED, and this byte is forwarded as the first byte of a packet.
  - Sync check with a byte ≠0x47 → HUNT. This byte is not re-evaluated as a HUNT candidate.
  - No output in VERIFY.
- LOCKED:
  - Sync check with 0x47: miss←0, and the packet is forwarded (this byte plus the following PKT_LEN-1 valid bytes).
  - Sync check with a byte ≠0x47:
    - miss+1, and the whole packet (this byte plus PKT_LEN-1 following valid bytes) is suppressed.
    - DROP_CNT+1.
    - If the incremented miss == LOSS_COUNT → HUNT, LOSS_CNT+1. The byte is not re-evaluated.
- Only the sync byte is checked. Payload content, TEI and PID are not inspected.
- CNT_CLR has priority over a same-cycle increment: the counter reads 0 afterwards.
- Counters are reset by RST only through their reset value. The lock state is not affected by CNT_CLR.

## Timing
- Output is registered: a forwarded input byte appears on TS_DATA_OUT/TS_DVALID_OUT exactly 1 cycle after its TS_DVALID_IN cycle. Input gaps are reproduced unchanged.
- TS_PSYNC_OUT is coincident with TS_DVALID_OUT for byte 0 only.
- LOCKED rises 1 cycle after the locking sync byte, aligned with its TS_PSYNC_OUT.
- LOCKED falls 1 cycle after the LOSS_COUNT-th bad sync byte.
- DROP_CNT and LOSS_CNT update 1 cycle after the triggering byte.
- When TS_DVALID_OUT=0, TS_DATA_OUT holds its last value and TS_PSYNC_OUT=0.
- Reset values:
  - TS_DATA_OUT=0x00, TS_DVALID_OUT=0, TS_PSYNC_OUT=0, LOCKED=0.
  - DROP_CNT=0, LOSS_CNT=0.
  - POS=0, hits=0, miss=0, state HUNT.
- RST mid-packet: outputs drop to reset values immediately. The partial packet is truncated downstream; the packer handles resync via PSYNC.

## Structure
- Shared package constants:
  - TS_SYNC_BYTE = 8'h47.
  - TS_PKT_LEN = 188.
  - FSM state encoding (3 states, 2 bits).
- One natural sub-module: ts_sat_counter (16-bit saturating counter with sync clear), instantiated for DROP_CNT and LOSS_CNT.
- POS width: $clog2(PKT_LEN).

## Test plan
- Clean stream of 5 packets, continuous valid:
  - Sync checks at input bytes 0, 188 and 376 give lock at byte 376. LOCKED=1 one cycle later.
  - Packets 3–5 are output with PSYNC at output cycles 377, 565 and 753.
  - DROP_CNT=0.
- Locked stream with packet 6's sync byte = 0x46:
  - Exactly 188 bytes suppressed, DROP_CNT=1, LOCKED stays 1.
  - Packet 7 is forwarded with PSYNC.
- Three consecutive bad syncs while locked:
  - 3 packets dropped, DROP_CNT=3, LOSS_CNT=1.
  - LOCKED falls 1 cycle after the third bad sync byte.
  - Relock after 3 good syncs.
- False 0x47 at payload offset 10 during HUNT:
  - VERIFY fails at the check 188 bytes later → HUNT.
  - Lock is achieved on true alignment afterwards, with no output before lock.
- Random 0–5 cycle gaps in TS_DVALID_IN:
  - Lock and output are identical in byte content to the gapless case.
  - Every output byte is exactly 1 cycle after its input.
- RST asserted at packet byte 50 while locked:
  - All outputs go to 0 asynchronously.
  - After release, the FSM is in HUNT and relocks after LOCK_COUNT syncs.
- CNT_CLR pulse coincident with a drop: DROP_CNT reads 0 afterwards.
